// File: rtl/if_stage_if.sv
// Bundle of the fetch-stage control inputs, program-load write port,
// IF/ID pipeline register outputs and debug event counters.
interface if_stage_if #(
  parameter int WORD_LEN   = 32,
  parameter int IMEM_WORDS = 64,
  parameter int CNT_W      = 16
);
  localparam int AW = $clog2(IMEM_WORDS);

  logic                freeze;
  logic                branch_taken;
  logic [WORD_LEN-1:0] branch_addr;
  logic                imem_we;
  logic [AW-1:0]       imem_waddr;
  logic [WORD_LEN-1:0] imem_wdata;
  logic [WORD_LEN-1:0] pc;
  logic [WORD_LEN-1:0] if_id_pc;
  logic [WORD_LEN-1:0] if_id_instr;
  logic                if_id_valid;
  logic [CNT_W-1:0]    fetch_cnt;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  // Hazard unit / execute / loader side
  modport master (
    output freeze, branch_taken, branch_addr,
    output imem_we, imem_waddr, imem_wdata,
    input  pc, if_id_pc, if_id_instr, if_id_valid,
    input  fetch_cnt, stall_cnt, flush_cnt
  );

  // Fetch stage side
  modport slave (
    input  freeze, branch_taken, branch_addr,
    input  imem_we, imem_waddr, imem_wdata,
    output pc, if_id_pc, if_id_instr, if_id_valid,
    output fetch_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction
// memory with combinational read, IF/ID pipeline register, stall/flush
// handling and saturating debug event counters.
module if_stage #(
  parameter int                  WORD_LEN   = 32,
  parameter int                  IMEM_WORDS = 64,
  parameter logic [WORD_LEN-1:0] RESET_PC   = {WORD_LEN{1'b0}},
  parameter int                  CNT_W      = 16
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.slave bus
);
  localparam int AW = $clog2(IMEM_WORDS);
  localparam logic [WORD_LEN-1:0] ZERO_W = {WORD_LEN{1'b0}};
  localparam logic [WORD_LEN-1:0] FOUR_W = {{(WORD_LEN-3){1'b0}}, 3'b100};
  localparam logic [WORD_LEN-1:0] ALIGN_MASK = {{(WORD_LEN-2){1'b1}}, 2'b00};
  localparam logic [CNT_W-1:0]    ZERO_C = {CNT_W{1'b0}};

  // Counter step that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Contents are left untouched by reset so a loaded program survives it
  logic [WORD_LEN-1:0] imem_r [IMEM_WORDS];

  logic [WORD_LEN-1:0] pc_r;
  logic [WORD_LEN-1:0] if_id_pc_r;
  logic [WORD_LEN-1:0] if_id_instr_r;
  logic                if_id_valid_r;
  logic [CNT_W-1:0]    fetch_cnt_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic [CNT_W-1:0]    flush_cnt_r;

  logic                in_range_s;
  logic [WORD_LEN-1:0] fetch_word_s;
  logic [WORD_LEN-1:0] pc_plus4_s;
  logic [WORD_LEN-1:0] branch_pc_s;

  // Combinational fetch; addresses beyond the array read back as a NOP
  always_comb begin
    in_range_s   = (pc_r[WORD_LEN-1:AW+2] == {(WORD_LEN-AW-2){1'b0}});
    pc_plus4_s   = pc_r + FOUR_W;
    branch_pc_s  = bus.branch_addr & ALIGN_MASK;
    fetch_word_s = ZERO_W;
    if (in_range_s) begin
      fetch_word_s = imem_r[pc_r[AW+1:2]];
    end else begin
      fetch_word_s = ZERO_W;
    end
  end

  // Program-load write port; the read above sees the pre-write word, and
  // a write coinciding with an edge while held in reset is discarded
  always_ff @(posedge clk) begin
    if (rst && bus.imem_we) begin
      imem_r[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  // PC / IF/ID sequencing: redirect beats stall, stall beats fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r          <= RESET_PC;
      if_id_pc_r    <= ZERO_W;
      if_id_instr_r <= ZERO_W;
      if_id_valid_r <= 1'b0;
      fetch_cnt_r   <= ZERO_C;
      stall_cnt_r   <= ZERO_C;
      flush_cnt_r   <= ZERO_C;
    end else if (bus.branch_taken) begin
      pc_r          <= branch_pc_s;
      if_id_pc_r    <= ZERO_W;
      if_id_instr_r <= ZERO_W;
      if_id_valid_r <= 1'b0;
      flush_cnt_r   <= sat_inc(flush_cnt_r);
    end else if (bus.freeze) begin
      stall_cnt_r   <= sat_inc(stall_cnt_r);
    end else begin
      pc_r          <= pc_plus4_s;
      if_id_pc_r    <= pc_plus4_s;
      if_id_instr_r <= fetch_word_s;
      if_id_valid_r <= 1'b1;
      fetch_cnt_r   <= sat_inc(fetch_cnt_r);
    end
  end

  assign bus.pc          = pc_r;
  assign bus.if_id_pc    = if_id_pc_r;
  assign bus.if_id_instr = if_id_instr_r;
  assign bus.if_id_valid = if_id_valid_r;
  assign bus.fetch_cnt   = fetch_cnt_r;
  assign bus.stall_cnt   = stall_cnt_r;
  assign bus.flush_cnt   = flush_cnt_r;
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected post-edge state,
// a monitor pops and compares after each clock edge or reset assertion.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;

  if_stage_if bus ();
  if_stage_if #(.CNT_W(4)) bus2 ();

  if_stage dut (.clk(clk), .rst(rst), .bus(bus));
  if_stage #(.CNT_W(4)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          sat;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    logic [15:0] f;
    logic [15:0] s;
    logic [15:0] fl;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int sid = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h want %h", nm, id, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ifpc, input logic [31:0] instr,
                              input logic v, input int f, input int s, input int fl);
    exp_t e;
    sid++;
    e.id = sid; e.sat = 1'b0; e.pc = pc; e.ifpc = ifpc; e.instr = instr; e.valid = v;
    e.f = 16'(f); e.s = 16'(s); e.fl = 16'(fl);
    return e;
  endfunction

  // Monitor: compare after each edge or reset assertion when something is expected
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sat) begin
          chk("sat_fetch_cnt", e.id, {28'd0, bus2.fetch_cnt}, {16'd0, e.f});
        end else begin
          chk("pc", e.id, bus.pc, e.pc);
          chk("if_id_pc", e.id, bus.if_id_pc, e.ifpc);
          chk("if_id_instr", e.id, bus.if_id_instr, e.instr);
          chk("if_id_valid", e.id, {31'd0, bus.if_id_valid}, {31'd0, e.valid});
          chk("fetch_cnt", e.id, {16'd0, bus.fetch_cnt}, {16'd0, e.f});
          chk("stall_cnt", e.id, {16'd0, bus.stall_cnt}, {16'd0, e.s});
          chk("flush_cnt", e.id, {16'd0, bus.flush_cnt}, {16'd0, e.fl});
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge
  task automatic step(input logic fz, input logic br, input logic [31:0] ba,
                      input logic we, input logic [5:0] wa, input logic [31:0] wd, input exp_t e);
    @(negedge clk);
    bus.freeze = fz; bus.branch_taken = br; bus.branch_addr = ba;
    bus.imem_we = we; bus.imem_waddr = wa; bus.imem_wdata = wd;
    q.push_back(e);
    @(posedge clk);
  endtask

  logic [31:0] words [4];

  initial begin
    exp_t e;
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = 32'h0;
    bus.imem_we = 1'b0; bus.imem_waddr = 6'd0; bus.imem_wdata = 32'h0;
    bus2.freeze = 1'b0; bus2.branch_taken = 1'b0; bus2.branch_addr = 32'h0;
    bus2.imem_we = 1'b0; bus2.imem_waddr = 6'd0; bus2.imem_wdata = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0));

    // program load with the stage frozen, then re-reset to clear counters
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b1; bus.freeze = 1'b1;
      bus.imem_we = 1'b1; bus.imem_waddr = 6'(i); bus.imem_wdata = words[i];
    end
    @(negedge clk);
    bus.imem_we = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus.freeze = 1'b0;
    q.push_back(mk(32'd4, 32'd4, 32'h11111111, 1'b1, 1, 0, 0));

    // sequential fetch
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd8, 32'd8, 32'h22222222, 1'b1, 2, 0, 0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd12, 32'd12, 32'h33333333, 1'b1, 3, 0, 0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd16, 32'd16, 32'h44444444, 1'b1, 4, 0, 0));
    // back to 4 so 0x22222222 sits in IF/ID for the stall
    step(1'b0, 1'b1, 32'd4, 1'b0, 6'd0, 32'h0, mk(32'd4, 32'd0, 32'h0, 1'b0, 4, 0, 1));
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd8, 32'd8, 32'h22222222, 1'b1, 5, 0, 1));
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd8, 32'd8, 32'h22222222, 1'b1, 5, k, 1));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd12, 32'd12, 32'h33333333, 1'b1, 6, 3, 1));
    // branch with freeze: branch wins, low address bits dropped
    step(1'b1, 1'b1, 32'h0000000B, 1'b0, 6'd0, 32'h0, mk(32'd8, 32'd0, 32'h0, 1'b0, 6, 3, 2));
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd12, 32'd12, 32'h33333333, 1'b1, 7, 3, 2));
    // out of range fetch
    step(1'b0, 1'b1, 32'h00000100, 1'b0, 6'd0, 32'h0, mk(32'h100, 32'd0, 32'h0, 1'b0, 7, 3, 3));
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'h104, 32'h104, 32'h0, 1'b1, 8, 3, 3));
    // PC wrap
    step(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 6'd0, 32'h0, mk(32'hFFFFFFFC, 32'd0, 32'h0, 1'b0, 8, 3, 4));
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd0, 32'd0, 32'h0, 1'b1, 9, 3, 4));
    // read-before-write at pc=4, then write together with a branch
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd4, 32'd4, 32'h11111111, 1'b1, 10, 3, 4));
    step(1'b0, 1'b0, 32'h0, 1'b1, 6'd1, 32'hDEADBEEF, mk(32'd8, 32'd8, 32'h22222222, 1'b1, 11, 3, 4));
    step(1'b0, 1'b1, 32'd4, 1'b1, 6'd2, 32'h55555555, mk(32'd4, 32'd0, 32'h0, 1'b0, 11, 3, 5));
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd8, 32'd8, 32'hDEADBEEF, 1'b1, 12, 3, 5));
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, mk(32'd12, 32'd12, 32'h55555555, 1'b1, 13, 3, 5));

    // asynchronous reset pulse between edges; memory survives
    @(negedge clk);
    q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0));
    rst = 1'b0;
    #2;
    rst = 1'b1;
    q.push_back(mk(32'd4, 32'd4, 32'h11111111, 1'b1, 1, 0, 0));
    @(posedge clk);

    // counter saturation on the CNT_W=4 instance
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      rst2 = 1'b1;
      e = mk(32'h0, 32'h0, 32'h0, 1'b0, (n > 15) ? 15 : n, 0, 0);
      e.sat = 1'b1;
      q.push_back(e);
      @(posedge clk);
    end

    // every queued expectation must have been consumed
    repeat (2) @(negedge clk);
    chk("queue_drained", 0, 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of decode. Holds the program counter, reads a word-addressed instruction memory, and registers the result into the IF/ID pipeline register. Handles hazard-unit stalls (freeze) and branch redirects (flush). Keeps saturating event counters for waveform-level debugging.

## Interface
- WORD_LEN, 32, instruction and address width
- IMEM_WORDS, 64, instruction memory depth in words (power of two, ≥ 2)
- RESET_PC, 0, PC value loaded at reset (word aligned)
- CNT_W, 16, width of each event counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- freeze  input  1  stall request from hazard unit; hold PC and IF/ID
- branch_taken  input  1  redirect request from execute
- branch_addr  input  WORD_LEN  redirect target; bits [1:0] ignored, treated as 0
- imem_we  input  1  instruction memory write enable (program load)
- imem_waddr  input  log2(IMEM_WORDS)  write word index
- imem_wdata  input  WORD_LEN  write data
- pc  output  WORD_LEN  current fetch address
- if_id_pc  output  WORD_LEN  PC+4 of the registered instruction
- if_id_instr  output  WORD_LEN  registered instruction
- if_id_valid  output  1  1 = real instruction, 0 = bubble
- fetch_cnt, stall_cnt, flush_cnt  output  CNT_W  saturating event counters

## Operation
- Fetch read is combinational: word = imem[pc[log2(IMEM_WORDS)+1:2]] when pc < 4·IMEM_WORDS, else 32'h0 (NOP).
- One action per rising edge, in priority order:
  - branch_taken=1:
    - pc ← {branch_addr[WORD_LEN-1:2], 2'b00}.
    - IF/ID ← bubble (if_id_instr=0, if_id_pc=0, if_id_valid=0).
    - flush_cnt increments.
    - Overrides freeze.
  - else freeze=1:
    - pc and all IF/ID outputs hold.
    - stall_cnt increments.
  - else (normal fetch):
    - pc ← pc+4, modulo 2^WORD_LEN; wrap from 32'hFFFFFFFC to 0 is legal.
    - if_id_pc ← pc+4; if_id_instr ← fetched word; if_id_valid ← 1.
    - fetch_cnt increments.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Instruction memory writes are synchronous on the rising edge when imem_we=1.
  - Read-before-write: a fetch of the same word in the same cycle returns the old contents.
  - Writes are independent of freeze and branch_taken.
- Memory contents are not cleared by reset; initial contents are 0.

## Timing
- Reset (rst=0), immediately and asynchronously: pc=RESET_PC; if_id_pc=0; if_id_instr=0; if_id_valid=0; all counters=0.
- Reset mid-operation discards any in-flight IF/ID contents. imem writes in that cycle are dropped.
- First fetch occurs on the first rising edge with rst=1. The instruction at RESET_PC appears on if_id_* after that edge.
- Fetch latency: 1 cycle from pc to if_id_instr.
- Redirect:
  - Branch asserted in cycle N gives a bubble on IF/ID in cycle N+1.
  - The target instruction appears in cycle N+2.
  - Exactly one bubble per taken branch.
- freeze held for k cycles holds if_id_* constant for k cycles. No instruction is lost or duplicated.
- branch_taken and freeze both high: branch wins; freeze is not counted in stall_cnt.
- Simultaneous branch_taken and imem_we: both take effect.

## Test plan
- Reset release, sequential fetch:
  - Stimulus: load imem[0..3]=32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444; release rst.
  - Required: if_id_instr shows those values on successive cycles; if_id_pc=4, 8, 12, 16; fetch_cnt=4.
- Stall:
  - Stimulus: freeze=1 for 3 cycles while if_id_instr=32'h22222222.
  - Required: outputs hold 3 cycles, then 32'h33333333 follows; stall_cnt=3; pc unchanged during freeze.
- Branch plus freeze:
  - Stimulus: branch_taken=1, freeze=1, branch_addr=32'h0000000B.
  - Required: next cycle if_id_valid=0, pc=32'h00000008; following cycle if_id_instr=imem[2]; flush_cnt=1, stall_cnt unchanged.
- Out of range and wrap:
  - Out of range: branch to 4·IMEM_WORDS gives if_id_instr=0 with if_id_valid=1.
  - Wrap: branch to 32'hFFFFFFFC, then one fetch gives pc=0.
- Read-before-write and async reset:
  - Read-before-write: write imem[1]=32'hDEADBEEF in the same cycle pc=4; IF/ID gets the old word. Refetching address 4 gives 32'hDEADBEEF.
  - Async reset: pulse rst=0 between clock edges; all outputs and counters clear immediately; pc=RESET_PC.
- Counter saturation:
  - Stimulus: CNT_W=4, run 20 fetches.
  - Required: fetch_cnt stays at 15.
